// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM BIST debug-bus sequencer.
// Holds the BIST opcodes, the sequencer state enum and the per-phase nibble counts.
package sram_bist_pkg;

  localparam int BIST_OP_WIDTH = 3;
  typedef logic [BIST_OP_WIDTH-1:0] bist_op_t;

  localparam bist_op_t OP_NOP                = 3'd0;
  localparam bist_op_t BIST_OP_SHIFT_ID      = 3'd1;
  localparam bist_op_t BIST_OP_SHIFT_BSEL    = 3'd2;
  localparam bist_op_t BIST_OP_SHIFT_ADDRESS = 3'd3;
  localparam bist_op_t BIST_OP_SHIFT_DATA    = 3'd4;
  localparam bist_op_t BIST_OP_READ          = 3'd5;

  localparam int CNT_W     = 7;
  localparam int ID_NIB    = 2;
  localparam int BSEL_NIB  = 2;
  localparam int ADDR_NIB  = 4;
  localparam int WR_NIB    = 80;
  localparam int RD_NIB    = 96;
  localparam int WR_COMMIT = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SH_ID,
    S_SH_BSEL,
    S_SH_ADDR,
    S_RD_CMD,
    S_RD_GAP,
    S_RD_SHIFT,
    S_WR_SHIFT,
    S_WR_COMMIT,
    S_RESP
  } bist_state_t;

  function automatic logic [CNT_W-1:0] last_nib(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sram_bist_sequencer_if.sv
// Request/response handshake bundle between the JTAG decoder and the sequencer.
// master = requester (JTAG side), slave = sequencer.
interface sram_bist_sequencer_if #(
  parameter int REQ_W = 320,
  parameter int RSP_W = 384
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [7:0]       req_sram_id;
  logic [7:0]       req_chunk_id;
  logic [15:0]      req_addr;
  logic [REQ_W-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RSP_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_sram_id,
    output req_chunk_id, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_sram_id,
    input  req_chunk_id, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bist_nibble_shifter.sv
// Width-parameterised shift register: parallel load, shifts left one nibble.
// Ports: clk, rst_n, load/load_val, shift/shift_in (enters LSB), q (MSB nibble leaves first).
module bist_nibble_shifter #(
  parameter int W     = 320,
  parameter int BUS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             shift,
  input  logic [BUS_W-1:0] shift_in,
  output logic [W-1:0]     q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-BUS_W-1:0], shift_in};
    end
  end
endmodule

// File: rtl/sram_bist_sequencer.sv
// Serialises one SRAM BIST read/write onto the nibble command/data bus.
// Ports: clk, rst_n, bus (req/rsp handshake), bist_command/bist_data out, bist_rdata in, busy.
module sram_bist_sequencer
  import sram_bist_pkg::*;
#(
  parameter int BUS_W = 4,
  parameter int REQ_W = 320,
  parameter int RSP_W = 384
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sram_bist_sequencer_if.slave     bus,
  output logic [BIST_OP_WIDTH-1:0] bist_command,
  output logic [BUS_W-1:0]         bist_data,
  input  logic [BUS_W-1:0]         bist_rdata,
  output logic                     busy
);
  bist_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic [7:0]       id_q, chunk_q;
  logic [15:0]      addr_q;
  logic [REQ_W-1:0] wr_q;
  logic [RSP_W-1:0] rd_q, rsp_q;
  logic             accept, rd_done;
  logic [7:0]       id_sh, chunk_sh;
  logic [15:0]      addr_sh;
  logic             unused_bits;

  assign accept  = bus.req_valid && (state_q == S_IDLE);
  assign rd_done = (state_q == S_RD_SHIFT) &&
                   (cnt_q == last_nib(RD_NIB));

  assign id_sh    = id_q << {cnt_q[0], 2'b00};
  assign chunk_sh = chunk_q << {cnt_q[0], 2'b00};
  assign addr_sh  = addr_q << {cnt_q[1:0], 2'b00};

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_q;
  assign busy          = (state_q != S_IDLE);

  // Only the MSB nibble of the write shifter is driven out; the
  // top nibble of the read shifter is overwritten by the final shift.
  assign unused_bits = ^{wr_q[REQ_W-BUS_W-1:0],
                         rd_q[RSP_W-1 -: BUS_W]};

  bist_nibble_shifter #(.W(REQ_W), .BUS_W(BUS_W)) u_wr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (bus.req_wdata),
    .shift    (state_q == S_WR_SHIFT),
    .shift_in ('0),
    .q        (wr_q)
  );

  bist_nibble_shifter #(.W(RSP_W), .BUS_W(BUS_W)) u_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ('0),
    .shift    (state_q == S_RD_SHIFT),
    .shift_in (bist_rdata),
    .q        (rd_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      id_q    <= '0;
      chunk_q <= '0;
      addr_q  <= '0;
      rsp_q   <= '0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        id_q    <= bus.req_sram_id;
        chunk_q <= bus.req_chunk_id;
        addr_q  <= bus.req_addr;
      end
      // Last nibble is sampled on the same edge the shifter takes it.
      if (rd_done) begin
        rsp_q <= {rd_q[RSP_W-BUS_W-1:0], bist_rdata};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bist_command = OP_NOP;
    bist_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = S_SH_ID;
      end
      S_SH_ID: begin
        bist_command = BIST_OP_SHIFT_ID;
        bist_data    = id_sh[7 -: BUS_W];
        if (cnt_q == last_nib(ID_NIB)) state_d = S_SH_BSEL;
      end
      S_SH_BSEL: begin
        bist_command = BIST_OP_SHIFT_BSEL;
        bist_data    = chunk_sh[7 -: BUS_W];
        if (cnt_q == last_nib(BSEL_NIB)) state_d = S_SH_ADDR;
      end
      S_SH_ADDR: begin
        bist_command = BIST_OP_SHIFT_ADDRESS;
        bist_data    = addr_sh[15 -: BUS_W];
        if (cnt_q == last_nib(ADDR_NIB)) begin
          state_d = write_q ? S_WR_SHIFT : S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        bist_command = BIST_OP_READ;
        state_d      = S_RD_GAP;
      end
      S_RD_GAP: begin
        state_d = S_RD_SHIFT;
      end
      S_RD_SHIFT: begin
        bist_command = BIST_OP_SHIFT_DATA;
        if (rd_done) state_d = S_RESP;
      end
      S_WR_SHIFT: begin
        bist_command = BIST_OP_SHIFT_DATA;
        bist_data    = wr_q[REQ_W-1 -: BUS_W];
        if (cnt_q == last_nib(WR_NIB)) state_d = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        if (cnt_q == last_nib(WR_COMMIT)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Directed bench for sram_bist_sequencer with a behavioural BIST SRAM model.
// Model: SR_ID 0x25, chunk 0x00, 64-bit words, 64 entries.
module tb_sram_bist_sequencer;
  import sram_bist_pkg::*;

  localparam logic [7:0] SR_ID = 8'h25;
  localparam logic [63:0] W12 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] W03 = 64'h0123456789ABCDEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bist_sequencer_if bus ();
  logic [BIST_OP_WIDTH-1:0] bist_command;
  logic [3:0]               bist_data;
  logic [3:0]               bist_rdata;
  logic                     busy;

  sram_bist_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .bist_command (bist_command),
    .bist_data    (bist_data),
    .bist_rdata   (bist_rdata),
    .busy         (busy)
  );

  // SRAM BIST wrapper model
  logic [63:0]  mem [0:63];
  logic         mem_init = 1'b0;
  logic [7:0]   m_id, m_chunk;
  logic [15:0]  m_addr;
  logic [63:0]  m_wd;
  logic [383:0] m_out;
  logic         m_rd, m_wr;
  logic [1:0]   m_nop;
  logic         m_sel;

  assign m_sel      = (m_id == SR_ID) && (m_chunk == 8'h00);
  assign bist_rdata = (m_sel && m_rd) ? m_out[383:380] : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_rd  <= 1'b0;
      m_wr  <= 1'b0;
      m_nop <= '0;
      if (!mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= {32'h1000_0000 + i, 32'h0};
        mem[18]  <= W12;
        mem_init <= 1'b1;
      end
    end else begin
      case (bist_command)
        BIST_OP_SHIFT_ID: begin
          m_id  <= {m_id[3:0], bist_data};
          m_rd  <= 1'b0;
          m_wr  <= 1'b0;
          m_nop <= '0;
        end
        BIST_OP_SHIFT_BSEL:    m_chunk <= {m_chunk[3:0], bist_data};
        BIST_OP_SHIFT_ADDRESS: m_addr  <= {m_addr[11:0], bist_data};
        BIST_OP_READ: begin
          m_rd  <= 1'b1;
          m_out <= (m_addr < 16'd64) ? {320'b0, mem[m_addr[5:0]]} : '0;
        end
        BIST_OP_SHIFT_DATA: begin
          if (m_rd) m_out <= m_out << 4;
          else begin
            m_wd <= {m_wd[59:0], bist_data};
            m_wr <= 1'b1;
          end
        end
        OP_NOP: begin
          if (m_wr) begin
            m_nop <= m_nop + 2'd1;
            if (m_nop == 2'd1) begin
              if (m_sel && m_addr < 16'd64) mem[m_addr[5:0]] <= m_wd;
              m_wr <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  int n_tot = 0;
  int n_bad = 0;
  logic [2:0] cmd_log [0:127];
  logic [3:0] dat_log [0:127];

  task automatic chk(input string tag, input logic [383:0] got,
                     input logic [383:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [7:0] id,
                      input logic [7:0] ch, input logic [15:0] a,
                      input logic [319:0] wd);
    @(negedge clk);
    bus.req_write    = wr;
    bus.req_sram_id  = id;
    bus.req_chunk_id = ch;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i < 128) begin
        cmd_log[i] = bist_command;
        dat_log[i] = bist_data;
      end
      if (bus.rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] id, input logic [15:0] a,
                    input logic [63:0] exp, input string tag);
    int cyc;
    send(1'b0, id, 8'h00, a, '0);
    wait_rsp(cyc);
    chk({tag, "_lat"}, cyc, 107);
    chk(tag, bus.rsp_rdata, {320'b0, exp});
    ack();
  endtask

  initial begin
    int cyc;
    int n;
    logic [383:0] r0;
    logic [319:0] wd;
    logic [31:0] hdr;
    logic [2:0] ec;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_sram_id  = '0;
    bus.req_chunk_id = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", bist_command, OP_NOP);
    chk("rst_data", bist_data, 0);
    rst_n = 1'b1;

    rd(SR_ID, 16'h0012, W12, "rd12");
    chk("rd12_idle", bus.req_ready, 1);

    wd = {64'hA5A5_0F0F_1234_5678, 192'h0, W03};
    send(1'b1, SR_ID, 8'h00, 16'h0003, wd);
    wait_rsp(cyc);
    chk("wr_lat", cyc, 91);
    chk("wr_keep_rdata", bus.rsp_rdata, {320'b0, W12});
    chk("wr_pre", {cmd_log[1], dat_log[1]}, {BIST_OP_SHIFT_ID, 4'h2});
    chk("wr_first", {cmd_log[9], dat_log[9]}, {BIST_OP_SHIFT_DATA, 4'hA});
    chk("wr_last", {cmd_log[88], dat_log[88]}, {BIST_OP_SHIFT_DATA, 4'hF});
    chk("wr_commit", {cmd_log[89], cmd_log[90]}, {OP_NOP, OP_NOP});
    ack();
    rd(SR_ID, 16'h0003, W03, "rd03");
    rd(SR_ID, 16'h0012, W12, "rd12b");
    chk("mem_04", mem[4], {32'h1000_0004, 32'h0});

    send(1'b0, 8'hA5, 8'h3C, 16'hBEEF, '0);
    wait_rsp(cyc);
    chk("tr_lat", cyc, 107);
    chk("tr_rdata", bus.rsp_rdata, 0);
    hdr = 32'hA53CBEEF;
    for (int i = 1; i <= 8; i++) begin
      ec = (i <= 2) ? BIST_OP_SHIFT_ID :
           (i <= 4) ? BIST_OP_SHIFT_BSEL : BIST_OP_SHIFT_ADDRESS;
      chk($sformatf("tr_hdr%0d", i), {cmd_log[i], dat_log[i]},
          {ec, hdr[35-4*i -: 4]});
    end
    chk("tr_read", {cmd_log[9], dat_log[9]}, {BIST_OP_READ, 4'h0});
    chk("tr_gap", {cmd_log[10], dat_log[10]}, {OP_NOP, 4'h0});
    n = 0;
    for (int i = 11; i <= 106; i++)
      if (cmd_log[i] == BIST_OP_SHIFT_DATA && dat_log[i] == 4'h0) n++;
    chk("tr_shift_n", n, 96);
    chk("tr_resp_cmd", {cmd_log[107], dat_log[107]}, {OP_NOP, 4'h0});
    ack();

    send(1'b1, 8'h7F, 8'h00, 16'h0012, {5{64'h1111_1111_1111_1111}});
    wait_rsp(cyc);
    chk("u7f_wr_lat", cyc, 91);
    ack();
    rd(8'h7F, 16'h0012, 64'h0, "u7f_rd");
    rd(SR_ID, 16'h0012, W12, "u7f_keep");

    send(1'b1, SR_ID, 8'h00, 16'h0012, {5{64'h5555_5555_5555_5555}});
    for (int i = 1; i <= 40; i++) @(negedge clk);
    chk("mid_busy", {busy, bist_command}, {1'b1, BIST_OP_SHIFT_DATA});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ready", bus.req_ready, 1);
    chk("mid_idle", {busy, bus.rsp_valid}, 2'b00);
    chk("mid_nop", {bist_command, bist_data}, {OP_NOP, 4'h0});
    rst_n = 1'b1;
    rd(SR_ID, 16'h0012, W12, "mid_keep");

    @(negedge clk);
    bus.req_write    = 1'b0;
    bus.req_sram_id  = SR_ID;
    bus.req_chunk_id = 8'h00;
    bus.req_addr     = 16'h0003;
    bus.req_valid    = 1'b1;
    wait_rsp(cyc);
    chk("hold_lat", cyc, 107);
    r0 = bus.rsp_rdata;
    chk("hold_data", r0, {320'b0, W03});
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_rdata == r0 && !bus.req_ready) n++;
    end
    chk("hold_stable", n, 5);
    ack();
    chk("hold_gap", {bus.req_ready, busy}, 2'b10);
    @(negedge clk);
    chk("hold_acc", {busy, bist_command, bist_data},
        {1'b1, BIST_OP_SHIFT_ID, 4'h2});
    bus.req_valid = 1'b0;
    wait_rsp(cyc);
    chk("hold2_lat", cyc, 106);
    chk("hold2_data", bus.rsp_rdata, {320'b0, W03});
    ack();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
